// File: rtl/noc_rx_if.sv
// Bundle of the NoC-side 4-phase handshake and the consumer-side valid/ready bus
// of the receive depacketizer.
interface noc_rx_if #(
  parameter int unsigned WIDTH = 39
);
  logic             noc_req;
  logic [WIDTH-1:0] noc_data;
  logic             noc_ack;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_src;
  logic [2:0]       out_type;
  logic [27:0]      out_payload;

  modport master (
    output noc_req, noc_data, out_ready,
    input  noc_ack, out_valid, out_src, out_type, out_payload
  );

  modport slave (
    input  noc_req, noc_data, out_ready,
    output noc_ack, out_valid, out_src, out_type, out_payload
  );
endinterface

// File: rtl/noc_rx_depacketizer.sv
// NoC receive stage: synchronizes a 4-phase req/ack handshake, filters packets by
// destination, buffers hits in a FIFO and presents decoded fields over valid/ready.
module noc_rx_depacketizer #(
  parameter int unsigned WIDTH   = 39,
  parameter logic [3:0]  MY_ADDR = 4'd0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_rx_if.slave          bus,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned        PtrW    = $clog2(DEPTH);
  localparam logic [PtrW:0]      FullCnt = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]      CntOne  = 1;
  localparam logic [PtrW-1:0]    PtrOne  = 1;
  localparam logic [CNT_W-1:0]   StatOne = 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StAck = 2'd1} state_e;

  state_e           state_q, state_d;
  logic             ack_q, ack_d;
  logic             req_meta_q, req_s_q;
  logic [1:0]       sync_vld_q;
  logic             armed_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic [CNT_W-1:0] pkt_cnt_q, drop_cnt_q;
  logic             full, capture, addr_hit, push, pop;
  logic [WIDTH-1:0] head;

  assign full     = (count_q == FullCnt);
  assign addr_hit = (bus.noc_data[WIDTH-1 -: 4] == MY_ADDR);
  assign push     = capture & addr_hit;
  assign pop      = (count_q != '0) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_s_q && armed_q && !full) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push && pop) begin
      count_d = count_q - CntOne;
    end
  end

  // sync_vld_q marks req_s as a real sample rather than the reset value, so a
  // request still held across reset can never arm the receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= StIdle;
      ack_q      <= 1'b0;
    end else begin
      req_meta_q <= bus.noc_req;
      req_s_q    <= req_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      armed_q    <= armed_q | (sync_vld_q[1] & ~req_s_q);
      state_q    <= state_d;
      ack_q      <= ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.noc_data;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (capture) begin
      if (addr_hit) begin
        if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + StatOne;
      end else begin
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + StatOne;
      end
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.noc_ack     = ack_q;
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_src     = head[34:31];
  assign bus.out_type    = head[30:28];
  assign bus.out_payload = head[27:0];
  assign pkt_count       = pkt_cnt_q;
  assign drop_count      = drop_cnt_q;

endmodule
